// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner with frame-based debounce.
// Emits one non-zero note code per accepted press; code 0 means silence.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_row_n,
  output logic [3:0] o_col_n,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_down,
  output logic       o_multi_key,
  output logic [1:0] o_dbg_state
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0] DB_CNT = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  logic [3:0]        r_row_n;
  logic [SLOT_W-1:0] r_slot;
  logic [1:0]        r_col;
  logic [15:0]       r_snap;
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [3:0]        r_pend;
  logic [3:0]        r_key_code;
  logic              r_key_valid;
  logic              r_key_down;
  logic              r_multi_key;

  logic              w_slot_last;
  logic              w_frame_end;
  logic [15:0]       w_keys;
  logic [4:0]        w_nkeys;
  logic [3:0]        w_single_code;
  logic [3:0]        w_cand_code;
  logic              w_cand_multi;
  logic [3:0]        w_cnt_inc;

  state_t            w_state_nxt;
  logic [3:0]        w_cnt_nxt;
  logic [3:0]        w_pend_nxt;
  logic [3:0]        w_key_code_nxt;
  logic              w_key_valid_nxt;
  logic              w_key_down_nxt;
  logic              w_multi_key_nxt;

  assign w_slot_last = (r_slot == SLOT_LAST);
  assign w_frame_end = w_slot_last && (r_col == 2'd3);
  assign w_cnt_inc   = r_cnt + 4'd1;

  // Column 3 is sampled on the frame-end edge itself, so the frame view splices
  // the live row sample over the stored snapshot. Bit 15 (row 3, col 3) is unused.
  assign w_keys = {~r_row_n, r_snap[11:0]} & 16'h7FFF;

  always_comb begin
    w_nkeys       = 5'd0;
    w_single_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_keys[i]) begin
        w_nkeys       = w_nkeys + 5'd1;
        w_single_code = 4'(((i % 4) * 4) + (i / 4) + 1);
      end
    end
  end

  // A candidate code of 0 stands for both NONE and MULTI; pend/key_code are never 0.
  assign w_cand_code  = (w_nkeys == 5'd1) ? w_single_code : 4'd0;
  assign w_cand_multi = (w_nkeys > 5'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_n <= 4'hF;
      r_slot  <= '0;
      r_col   <= 2'd0;
      r_snap  <= 16'd0;
    end else begin
      r_row_n <= i_row_n;
      if (w_slot_last) begin
        r_slot                <= '0;
        r_snap[r_col*4 +: 4]  <= ~r_row_n;
        r_col                 <= r_col + 2'd1;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_pend      <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_multi_key <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_down  <= w_key_down_nxt;
      r_multi_key <= w_multi_key_nxt;
    end
  end

  // o_key_valid is a one-cycle strobe with no back-pressure: the consumer must
  // capture o_key_code on the cycle o_key_valid is high (code stays held afterwards).
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pend_nxt      = r_pend;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_down_nxt  = r_key_down;
    w_multi_key_nxt = r_multi_key;
    if (w_frame_end) begin
      w_multi_key_nxt = w_cand_multi;
      case (r_state)
        IDLE: begin
          if (w_cand_code != 4'd0) begin
            w_pend_nxt  = w_cand_code;
            w_cnt_nxt   = 4'd1;
            w_state_nxt = PRESS_DB;
          end else begin
            w_cnt_nxt = 4'd0;
          end
        end
        PRESS_DB: begin
          if (w_cand_code == r_pend) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DB_CNT) begin
              w_state_nxt     = HELD;
              w_key_code_nxt  = r_pend;
              w_key_valid_nxt = 1'b1;
              w_key_down_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = IDLE;
          end
        end
        HELD: begin
          if (w_cand_code != r_key_code) begin
            w_cnt_nxt   = 4'd1;
            w_state_nxt = REL_DB;
          end
        end
        REL_DB: begin
          if (w_cand_code == r_key_code) begin
            w_state_nxt = HELD;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DB_CNT) begin
              w_state_nxt    = IDLE;
              w_key_down_nxt = 1'b0;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign o_col_n     = ~(4'b0001 << r_col);
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_down  = r_key_down;
  assign o_multi_key = r_multi_key;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a frame-level key-matrix model drives the rows,
// a reference model predicts each frame's outputs and queues expected presses.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  localparam int P_IDLE  = 0;
  localparam int P_PRESS = 1;
  localparam int P_HELD  = 2;
  localparam int P_REL   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi_key;
  logic [1:0] dbg_state;

  // keys[r*4+c] = switch at row r, column c is closed; its note code is index+1
  logic [15:0] keys = 16'd0;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  int m_phase = P_IDLE;
  int m_cnt   = 0;
  int m_pend  = 0;
  int m_code  = 0;
  int m_down  = 0;
  int m_multi = 0;

  logic prev_valid = 1'b0;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_row_n    (row_n),
    .o_col_n    (col_n),
    .o_key_code (key_code),
    .o_key_valid(key_valid),
    .o_key_down (key_down),
    .o_multi_key(multi_key),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // passive matrix: a row is pulled low when a closed switch meets the driven column
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!col_n[c] && keys[r*4+c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // reference model: one call per scanned frame
  task automatic model_reset();
    m_phase = P_IDLE;
    m_cnt   = 0;
    m_pend  = 0;
    m_code  = 0;
    m_down  = 0;
    m_multi = 0;
  endtask

  task automatic model_frame(input logic [15:0] mask);
    int n;
    int k;
    int cand;
    n = 0;
    k = 0;
    for (int i = 0; i < 15; i++) begin
      if (mask[i]) begin
        n++;
        k = i + 1;
      end
    end
    cand    = (n == 1) ? k : 0;
    m_multi = (n > 1) ? 1 : 0;
    case (m_phase)
      P_IDLE: begin
        if (cand != 0) begin
          m_pend  = cand;
          m_cnt   = 1;
          m_phase = P_PRESS;
        end
      end
      P_PRESS: begin
        if (cand == m_pend) begin
          m_cnt++;
          if (m_cnt == DB) begin
            m_phase = P_HELD;
            m_code  = m_pend;
            m_down  = 1;
            exp_q.push_back(4'(m_pend));
          end
        end else begin
          m_phase = P_IDLE;
          m_cnt   = 0;
        end
      end
      P_HELD: begin
        if (cand != m_code) begin
          m_phase = P_REL;
          m_cnt   = 1;
        end
      end
      default: begin
        if (cand == m_code) begin
          m_phase = P_HELD;
        end else begin
          m_cnt++;
          if (m_cnt == DB) begin
            m_phase = P_IDLE;
            m_down  = 0;
          end
        end
      end
    endcase
  endtask

  // driver tasks
  task automatic check_reset_outputs();
    check("rst_col_n", int'(col_n), 4'b1110);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_down", int'(key_down), 0);
    check("rst_multi_key", int'(multi_key), 0);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    repeat (hold) @(negedge clk);
    check_reset_outputs();
    exp_q.delete();
    model_reset();
    reset = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] mask);
    logic [3:0] one_hot;
    logic [3:0] exp_col;
    keys = mask;
    model_frame(mask);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      one_hot = 4'b0001 << ((k / SCAN_DIV) % 4);
      exp_col = ~one_hot;
      check("col_n", int'(col_n), int'(exp_col));
    end
    #1;
    check("key_code", int'(key_code), m_code);
    check("key_down", int'(key_down), m_down);
    check("multi_key", int'(multi_key), m_multi);
    check("pulse_missing", exp_q.size(), 0);
  endtask

  task automatic run_frames(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) run_frame(mask);
  endtask

  task automatic partial_frame(input logic [15:0] mask, input int cycles);
    keys = mask;
    repeat (cycles) @(negedge clk);
  endtask

  // scoreboard monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      if (prev_valid) begin
        checks++;
        failures++;
        $display("FAIL pulse_width actual=2+ cycles required=1 cycle at %0t", $time);
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=code %0d required=no pulse at %0t", key_code, $time);
      end else begin
        check("pulse_code", int'(key_code), int'(exp_q.pop_front()));
      end
    end
    prev_valid <= key_valid;
  end

  initial begin
    logic [15:0] cur;
    int a;
    int b;
    int sel;
    int len;
    reset = 1'b1;
    keys  = 16'd0;
    @(negedge clk);
    do_reset(2);

    // idle scanning, col_n rotation
    run_frames(16'd0, 2);

    // row1/col2 -> code 7, then release
    run_frames(16'h0001 << 6, 4);
    run_frames(16'd0, 4);

    // bounce row0/col0 on alternate frames
    for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? 16'h0001 : 16'h0000);

    // row0/col0 with row2/col1 -> multi, then row2 released
    run_frames(16'h0001 | (16'h0001 << 9), 4);
    run_frames(16'h0001, 4);
    run_frames(16'd0, 4);

    // code 5 held, one open frame, closed again
    run_frames(16'h0001 << 4, 4);
    run_frame(16'd0);
    run_frames(16'h0001 << 4, 3);
    run_frames(16'd0, 4);

    // unmapped row3/col3 is ignored; alone and alongside a real key
    run_frames(16'h8000, 4);
    run_frames(16'h8000 | 16'h0004, 4);
    run_frames(16'd0, 4);

    // key A straight into key B with no gap
    run_frames(16'h0001 << 1, 4);
    run_frames(16'h0001 << 11, 6);
    run_frames(16'd0, 4);

    // reset in the middle of the press debounce, key kept closed
    run_frame(16'h0001 << 6);
    partial_frame(16'h0001 << 6, FRAME / 2);
    do_reset(3);
    run_frames(16'h0001 << 6, 4);
    run_frames(16'd0, 4);

    // randomized patterns, each held for a random number of frames
    cur = 16'd0;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        cur = 16'd0;
      end else if (sel < 8) begin
        a   = $urandom_range(0, 15);
        cur = 16'h0001 << a;
      end else begin
        a   = $urandom_range(0, 15);
        b   = $urandom_range(0, 15);
        cur = (16'h0001 << a) | (16'h0001 << b);
      end
      len = $urandom_range(1, 5);
      run_frames(cur, len);
    end
    run_frames(16'd0, 4);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
